// File: rtl/stage_memory_if.sv
// Request/stall/done bus between the memory pipeline stage and the multi-cycle data memory.
// The stage is the master: it drives the strobe, address and data, and the memory answers.
interface stage_memory_if;
  logic        MemEn;
  logic        MemWr;
  logic [15:0] MemAddr;
  logic [15:0] MemWriteData;
  logic        MemDump;
  logic [15:0] MemDataIn;
  logic        MemStall;
  logic        MemDone;

  modport master (
    output MemEn, MemWr, MemAddr, MemWriteData, MemDump,
    input  MemDataIn, MemStall, MemDone
  );

  modport slave (
    input  MemEn, MemWr, MemAddr, MemWriteData, MemDump,
    output MemDataIn, MemStall, MemDone
  );
endinterface

// File: rtl/stage_memory.sv
// Memory stage of the 5-stage pipeline: runs one data-memory access at a time, freezes upstream
// while an access is outstanding, and registers the MEM/WB outputs for writeback.
module stage_memory #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Valid,
  input  logic [15:0]    ALUResult,
  input  logic [15:0]    ReadData2,
  input  logic           DMemWriteIn,
  input  logic           DMemEnIn,
  input  logic           DMemDumpIn,
  input  logic           RegWriteIn,
  input  logic           MemToRegIn,
  input  logic [2:0]     WriteRegIn,
  input  logic [2:0]     SetSelectIn,
  output logic           Stall,
  stage_memory_if.master mem,
  output logic           WbValid,
  output logic [15:0]    ALUResultOut,
  output logic [15:0]    ReadDataOut,
  output logic           RegWriteOut,
  output logic           MemToRegOut,
  output logic [2:0]     WriteRegOut,
  output logic [2:0]     SetSelectOut,
  output logic           Err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic             r_wr;
  logic             r_regWrite;
  logic             r_memToReg;
  logic [2:0]       r_writeReg;
  logic [2:0]       r_setSelect;

  logic             r_wbValid;
  logic [15:0]      r_aluOut;
  logic [15:0]      r_readOut;
  logic             r_regWriteOut;
  logic             r_memToRegOut;
  logic [2:0]       r_writeRegOut;
  logic [2:0]       r_setSelectOut;
  logic             r_err;
  logic             r_dump;

  logic w_idleValid;
  logic w_busy;
  logic w_done;
  logic w_timeout;
  logic w_dumpReq;
  logic w_accept;
  logic w_misaligned;
  logic w_passRetire;

  assign w_idleValid  = (r_state == S_IDLE) && Valid;
  assign w_busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);
  // A strobe refused by MemStall cannot complete in the same cycle.
  assign w_done       = (((r_state == S_ISSUE) && !mem.MemStall) || (r_state == S_WAIT)) && mem.MemDone;
  assign w_timeout    = w_busy && !w_done && (r_cnt == LAST_CNT);
  assign w_dumpReq    = w_idleValid && DMemDumpIn;
  assign w_accept     = w_idleValid && !DMemDumpIn && DMemEnIn && !ALUResult[0];
  assign w_misaligned = w_idleValid && !DMemDumpIn && DMemEnIn && ALUResult[0];
  assign w_passRetire = w_idleValid && (DMemDumpIn || !DMemEnIn);

  assign mem.MemEn        = (r_state == S_ISSUE);
  assign mem.MemWr        = r_wr;
  assign mem.MemAddr      = r_addr;
  assign mem.MemWriteData = r_wdata;
  assign mem.MemDump      = r_dump;

  assign WbValid      = r_wbValid;
  assign ALUResultOut = r_aluOut;
  assign ReadDataOut  = r_readOut;
  assign RegWriteOut  = r_regWriteOut;
  assign MemToRegOut  = r_memToRegOut;
  assign WriteRegOut  = r_writeRegOut;
  assign SetSelectOut = r_setSelectOut;
  assign Err          = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    Stall       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_dumpReq)     w_nextState = S_HALT;
        else if (w_accept) w_nextState = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_done || w_timeout) w_nextState = S_IDLE;
        else if (!mem.MemStall)  w_nextState = S_WAIT;
      end
      S_WAIT: begin
        if (w_done || w_timeout) w_nextState = S_IDLE;
      end
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Latched request, wait counter and MEM/WB register; outputs hold between retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wr           <= 1'b0;
      r_regWrite     <= 1'b0;
      r_memToReg     <= 1'b0;
      r_writeReg     <= '0;
      r_setSelect    <= '0;
      r_wbValid      <= 1'b0;
      r_aluOut       <= '0;
      r_readOut      <= '0;
      r_regWriteOut  <= 1'b0;
      r_memToRegOut  <= 1'b0;
      r_writeRegOut  <= '0;
      r_setSelectOut <= '0;
      r_err          <= 1'b0;
      r_dump         <= 1'b0;
    end else begin
      r_wbValid <= 1'b0;
      r_dump    <= 1'b0;
      if (w_busy) r_cnt <= r_cnt + CNT_W'(1);
      if (w_passRetire || w_misaligned) begin
        r_wbValid      <= 1'b1;
        r_aluOut       <= ALUResult;
        r_readOut      <= '0;
        r_regWriteOut  <= RegWriteIn && !w_misaligned;
        r_memToRegOut  <= MemToRegIn;
        r_writeRegOut  <= WriteRegIn;
        r_setSelectOut <= SetSelectIn;
      end
      if (w_misaligned) r_err  <= 1'b1;
      if (w_dumpReq)    r_dump <= 1'b1;
      if (w_accept) begin
        r_cnt       <= '0;
        r_addr      <= ALUResult;
        r_wdata     <= ReadData2;
        r_wr        <= DMemWriteIn;
        r_regWrite  <= RegWriteIn;
        r_memToReg  <= MemToRegIn;
        r_writeReg  <= WriteRegIn;
        r_setSelect <= SetSelectIn;
      end
      // An abandoned access still retires so the pipeline drains, but never writes a register.
      if (w_done || w_timeout) begin
        r_wbValid      <= 1'b1;
        r_aluOut       <= r_addr;
        r_readOut      <= (w_done && !r_wr) ? mem.MemDataIn : 16'h0000;
        r_regWriteOut  <= r_regWrite && w_done;
        r_memToRegOut  <= r_memToReg;
        r_writeRegOut  <= r_writeReg;
        r_setSelectOut <= r_setSelect;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized bench for stage_memory: a transaction-level model predicts stall length, strobe count,
// the retired MEM/WB record and the sticky error flag for each instruction.
module tb_stage_memory;

  localparam int TIMEOUT = 8;
  localparam int MAX_CYC = 40;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        en;
    logic        wr;
    logic        dump;
    logic        rw;
    logic        m2r;
    logic [2:0]  wreg;
    logic [2:0]  ssel;
    int          stalls;
    int          lat;
    logic        never;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Valid = 1'b0;
  logic [15:0] ALUResult = '0;
  logic [15:0] ReadData2 = '0;
  logic        DMemWriteIn = 1'b0;
  logic        DMemEnIn = 1'b0;
  logic        DMemDumpIn = 1'b0;
  logic        RegWriteIn = 1'b0;
  logic        MemToRegIn = 1'b0;
  logic [2:0]  WriteRegIn = '0;
  logic [2:0]  SetSelectIn = '0;
  logic        Stall;
  logic        WbValid;
  logic [15:0] ALUResultOut;
  logic [15:0] ReadDataOut;
  logic        RegWriteOut;
  logic        MemToRegOut;
  logic [2:0]  WriteRegOut;
  logic [2:0]  SetSelectOut;
  logic        Err;

  int   checks = 0;
  int   failures = 0;
  logic expErr = 1'b0;
  int   stallLeft = 0;
  int   waitLeft = 0;
  bit   accepted = 1'b0;

  stage_memory_if memBus ();

  stage_memory #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .Valid        (Valid),
    .ALUResult    (ALUResult),
    .ReadData2    (ReadData2),
    .DMemWriteIn  (DMemWriteIn),
    .DMemEnIn     (DMemEnIn),
    .DMemDumpIn   (DMemDumpIn),
    .RegWriteIn   (RegWriteIn),
    .MemToRegIn   (MemToRegIn),
    .WriteRegIn   (WriteRegIn),
    .SetSelectIn  (SetSelectIn),
    .Stall        (Stall),
    .mem          (memBus),
    .WbValid      (WbValid),
    .ALUResultOut (ALUResultOut),
    .ReadDataOut  (ReadDataOut),
    .RegWriteOut  (RegWriteOut),
    .MemToRegOut  (MemToRegOut),
    .WriteRegOut  (WriteRegOut),
    .SetSelectOut (SetSelectOut),
    .Err          (Err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_wbvalid", WbValid, 0);
    checkOutput("rst_alu", ALUResultOut, 0);
    checkOutput("rst_read", ReadDataOut, 0);
    checkOutput("rst_regwrite", RegWriteOut, 0);
    checkOutput("rst_memtoreg", MemToRegOut, 0);
    checkOutput("rst_writereg", WriteRegOut, 0);
    checkOutput("rst_setsel", SetSelectOut, 0);
    checkOutput("rst_err", Err, 0);
    checkOutput("rst_dump", memBus.MemDump, 0);
    checkOutput("rst_memen", memBus.MemEn, 0);
    checkOutput("rst_stall", Stall, 0);
  endtask

  function automatic txn_t newTxn(input logic [15:0] addr, input logic en, input logic wr);
    txn_t t;
    t.addr   = addr;
    t.en     = en;
    t.wr     = wr;
    t.wdata  = 16'($urandom);
    t.rdata  = 16'($urandom);
    t.dump   = 1'b0;
    t.rw     = 1'($urandom);
    t.m2r    = 1'($urandom);
    t.wreg   = 3'($urandom);
    t.ssel   = 3'($urandom);
    t.stalls = 0;
    t.lat    = 0;
    t.never  = 1'b0;
    return t;
  endfunction

  task automatic driveInputs(input txn_t t);
    Valid       = 1'b1;
    ALUResult   = t.addr;
    ReadData2   = t.wdata;
    DMemWriteIn = t.wr;
    DMemEnIn    = t.en;
    DMemDumpIn  = t.dump;
    RegWriteIn  = t.rw;
    MemToRegIn  = t.m2r;
    WriteRegIn  = t.wreg;
    SetSelectIn = t.ssel;
  endtask

  // Memory responder: refuses the first t.stalls strobes, then answers t.lat cycles after acceptance.
  task automatic respond(input txn_t t);
    memBus.MemStall  = 1'b0;
    memBus.MemDone   = 1'b0;
    memBus.MemDataIn = 16'($urandom);
    if (memBus.MemEn) begin
      if (stallLeft > 0) begin
        memBus.MemStall = 1'b1;
        stallLeft--;
      end else begin
        accepted = 1'b1;
        waitLeft = t.lat;
      end
    end else if (accepted) begin
      waitLeft--;
    end
    if (accepted && waitLeft <= 0 && !t.never) begin
      memBus.MemDone   = 1'b1;
      memBus.MemDataIn = t.rdata;
      accepted         = 1'b0;
    end
  endtask

  task automatic applyStimulus(input txn_t t);
    bit          misaligned;
    bit          aligned;
    bit          complete;
    int          total;
    int          expStall;
    int          expEn;
    int          stallCnt;
    int          enCnt;
    int          cycles;
    logic [15:0] expRead;
    logic        expRW;
    misaligned = t.en && t.addr[0];
    aligned    = t.en && !t.addr[0];
    total      = t.stalls + 1 + t.lat;
    complete   = !t.never && (total <= TIMEOUT);
    expStall   = 0;
    expEn      = 0;
    if (aligned) begin
      expStall = complete ? total : TIMEOUT;
      expEn    = (t.stalls + 1 < expStall) ? t.stalls + 1 : expStall;
    end
    expRead = (aligned && complete && !t.wr) ? t.rdata : 16'h0000;
    expRW   = t.rw && !misaligned && !(aligned && !complete);
    if (misaligned || (aligned && !complete)) expErr = 1'b1;

    driveInputs(t);
    stallLeft = t.stalls;
    waitLeft  = 0;
    accepted  = 1'b0;
    respond(t);
    stallCnt = 0;
    enCnt    = 0;
    cycles   = 0;
    do begin
      @(negedge clk);
      Valid = 1'b0;
      respond(t);
      cycles++;
      if (Stall) begin
        stallCnt++;
        checkOutput("mem_addr", memBus.MemAddr, t.addr);
        checkOutput("mem_wr", memBus.MemWr, t.wr);
        checkOutput("mem_wdata", memBus.MemWriteData, t.wdata);
      end
      if (memBus.MemEn) enCnt++;
    end while (!WbValid && cycles < MAX_CYC);
    if (!WbValid) checkOutput("retire_bound", 0, 1);
    checkOutput("stall_cycles", stallCnt, expStall);
    checkOutput("memen_cycles", enCnt, expEn);
    checkOutput("stall_released", Stall, 0);
    checkOutput("wb_alu", ALUResultOut, t.addr);
    checkOutput("wb_read", ReadDataOut, expRead);
    checkOutput("wb_regwrite", RegWriteOut, expRW);
    checkOutput("wb_memtoreg", MemToRegOut, t.m2r);
    checkOutput("wb_writereg", WriteRegOut, t.wreg);
    checkOutput("wb_setsel", SetSelectOut, t.ssel);
    checkOutput("err", Err, expErr);
  endtask

  initial begin
    txn_t t;
    memBus.MemStall  = 1'b0;
    memBus.MemDone   = 1'b0;
    memBus.MemDataIn = '0;
    repeat (2) @(negedge clk);
    checkReset();
    rst = 1'b0;

    // Directed scenarios.
    t = newTxn(16'h1234, 1'b0, 1'b0);
    t.rw = 1'b1; t.wreg = 3'd5;
    applyStimulus(t);
    t = newTxn(16'h0040, 1'b1, 1'b0);
    t.lat = 3; t.rdata = 16'hBEEF; t.m2r = 1'b1;
    applyStimulus(t);
    t = newTxn(16'h0010, 1'b1, 1'b1);
    t.wdata = 16'h00AA; t.stalls = 2; t.lat = 1;
    applyStimulus(t);
    t = newTxn(16'h0200, 1'b1, 1'b0);
    t.lat = TIMEOUT - 1;
    applyStimulus(t);
    t = newTxn(16'h0011, 1'b1, 1'b0);
    t.rw = 1'b1;
    applyStimulus(t);
    t = newTxn(16'h0300, 1'b1, 1'b0);
    t.never = 1'b1; t.rw = 1'b1;
    applyStimulus(t);
    t = newTxn(16'h0400, 1'b1, 1'b0);
    t.stalls = 1; t.lat = TIMEOUT - 1; t.rw = 1'b1;
    applyStimulus(t);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expErr = 1'b0;
    checkReset();

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      t = newTxn(16'($urandom), kind >= 3, 1'($urandom));
      if (kind >= 3 && kind <= 8) t.addr[0] = 1'b0;
      if (kind == 9) t.addr[0] = 1'b1;
      t.stalls = int'($urandom_range(0, 3));
      t.lat    = int'($urandom_range(0, 6));
      t.never  = ($urandom_range(0, 15) == 0);
      applyStimulus(t);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        checkOutput("idle_wbvalid", WbValid, 0);
      end
    end

    // Reset while an access is outstanding.
    t = newTxn(16'h0500, 1'b1, 1'b0);
    t.never = 1'b1;
    driveInputs(t);
    stallLeft = 0; waitLeft = 0; accepted = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Valid = 1'b0;
      respond(t);
    end
    checkOutput("midaccess_stall", Stall, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expErr = 1'b0;
    memBus.MemStall = 1'b0;
    memBus.MemDone  = 1'b0;
    checkReset();

    // Dump, halt, then recover through reset.
    t = newTxn(16'h0ABC, 1'($urandom), 1'b0);
    t.dump = 1'b1;
    driveInputs(t);
    @(negedge clk);
    checkOutput("dump_pulse", memBus.MemDump, 1);
    checkOutput("dump_wbvalid", WbValid, 1);
    checkOutput("dump_alu", ALUResultOut, t.addr);
    checkOutput("dump_read", ReadDataOut, 0);
    checkOutput("dump_regwrite", RegWriteOut, t.rw);
    checkOutput("dump_writereg", WriteRegOut, t.wreg);
    checkOutput("dump_setsel", SetSelectOut, t.ssel);
    checkOutput("dump_stall", Stall, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("halt_dump", memBus.MemDump, 0);
      checkOutput("halt_stall", Stall, 1);
      checkOutput("halt_wbvalid", WbValid, 0);
      checkOutput("halt_memen", memBus.MemEn, 0);
    end
    Valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset();

    t = newTxn(16'h0042, 1'b1, 1'b0);
    t.lat = 2;
    applyStimulus(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
Memory stage of the 5-stage pipeline. It consumes the execute-stage results: ALU result as the address, ReadData2 as the store data, and the passthrough control. It drives a multi-cycle data memory through a request/stall/done handshake and freezes upstream stages while an access is outstanding. It registers the MEM/WB outputs for writeback, and handles the halt dump, misaligned accesses and access timeout.

Parameters:
TIMEOUT, 64, max cycles an access may stay in ISSUE+WAIT before it is abandoned with Err.
CNT_W, 7, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
Valid  in  1  execute stage presents an instruction this cycle.
ALUResult  in  16  address or result from execute.
ReadData2  in  16  store data.
DMemWriteIn  in  1  store when 1, load when 0 (only meaningful with DMemEnIn).
DMemEnIn  in  1  memory access requested.
DMemDumpIn  in  1  halt; dump memory.
RegWriteIn, MemToRegIn  in  1 each  writeback control passthrough.
WriteRegIn, SetSelectIn  in  3 each  writeback passthrough.
Stall  out  1  upstream must hold its outputs; combinational from state.
MemEn  out  1  memory request strobe.
MemWr  out  1  request is a write.
MemAddr  out  16  request address.
MemWriteData  out  16  store data.
MemDump  out  1  one-cycle dump pulse.
MemDataIn  in  16  load data, valid with MemDone.
MemStall  in  1  memory refused the strobe this cycle.
MemDone  in  1  access complete.
WbValid  out  1  MEM/WB register holds a retired instruction.
ALUResultOut, ReadDataOut  out  16 each  registered results.
RegWriteOut, MemToRegOut  out  1 each  registered control.
WriteRegOut, SetSelectOut  out  3 each  registered passthrough.
Err  out  1  sticky error flag.

Behaviour:
- Reset: every registered output is 0. State is IDLE, counter is 0, Err is 0.
- Reset mid-access: the in-flight operation is dropped, and MemEn is 0 from the next cycle.
- States:
  - IDLE: Stall=0.
  - ISSUE: Stall=1, MemEn=1.
  - WAIT: Stall=1, MemEn=0.
  - HALT: Stall=1 forever.
- IDLE with Valid=0: WbValid is 0 next cycle.
- IDLE, Valid, DMemEnIn=0, DMemDumpIn=0: retire in 1 cycle.
  - WbValid=1 next cycle.
  - Outputs take the inputs directly; ReadDataOut=0.
- IDLE, Valid, DMemEnIn=1, ALUResult[0]=0:
  - Latch address, data, write flag and writeback control.
  - Go to ISSUE; WbValid=0 next cycle.
  - MemAddr, MemWr and MemWriteData are driven from the latch and are stable through ISSUE and WAIT.
- IDLE, Valid, DMemEnIn=1, ALUResult[0]=1 (misaligned):
  - No memory request is issued.
  - Retire next cycle with RegWriteOut=0; Err goes to 1.
- ISSUE transitions:
  - MemStall=1: stay in ISSUE and re-strobe.
  - MemStall=0, MemDone=1: complete.
  - MemStall=0, MemDone=0: go to WAIT.
- WAIT: MemDone=1 completes the access.
- Complete:
  - Next cycle WbValid=1, with the latched control and ALUResultOut = latched address.
  - Loads set ReadDataOut = MemDataIn as sampled on the MemDone cycle; stores set ReadDataOut=0.
  - Return to IDLE; Stall is 0 in that same cycle.
- Wait counter:
  - Cleared on entry to ISSUE; increments each ISSUE/WAIT cycle.
  - If the counter reaches TIMEOUT-1 without MemDone, set Err and retire next cycle with RegWriteOut=0, then go to IDLE.
  - MemDone on that same cycle takes priority and completes normally.
- Dump (Valid, DMemDumpIn=1 in IDLE, regardless of DMemEnIn):
  - MemDump=1 for exactly one cycle (the next cycle).
  - Retire with WbValid=1 and the passthrough values, then enter HALT.
  - MemDump never re-pulses; only rst leaves HALT.
- Err: sticky until rst.
- Upstream rule: inputs are sampled only in IDLE. The upstream stage must hold Valid and its data while Stall=1.

Test Plan:
- Non-memory instruction: Valid, ALUResult=0x1234, RegWriteIn=1, WriteRegIn=5 -> next cycle WbValid=1, ALUResultOut=0x1234, WriteRegOut=5, Stall never 1.
- Load with MemDone 3 cycles after strobe: ALUResult=0x0040 -> MemEn high 1 cycle with MemAddr=0x0040 and MemWr=0; Stall high 4 cycles; MemDataIn=0xBEEF on the done cycle -> ReadDataOut=0xBEEF, MemToRegOut=1.
- Store with MemStall=1 for 2 cycles: ALUResult=0x0010, ReadData2=0x00AA -> MemEn held 3 cycles with MemWr=1 and MemWriteData=0x00AA; completes on MemDone; ReadDataOut=0.
- Misaligned load at 0x0011 -> MemEn stays 0; next cycle WbValid=1, RegWriteOut=0, Err=1 and remains 1 across later instructions.
- Timeout: load with MemDone never asserted and TIMEOUT=8 -> Err=1 after 8 wait cycles; retire with RegWriteOut=0; state returns to IDLE.
- Dump then reset: DMemDumpIn=1 -> MemDump pulse of width 1, Stall=1 indefinitely; asserting rst mid-halt -> all outputs 0 and Stall=0 on the cycle after rst.
